mem_req_sched: RTL

//   Request scheduler in front of the banked 8-bit mem block. Buffers read/write requests

---
 rtl/mem_req_sched.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_req_sched.sv
// Request scheduler for the banked mem block: in-order request FIFO, one issue register
// driving mem directly, and a credit-protected response FIFO returning read data in order.
module mem_req_sched #(
    parameter int DEPTH     = 4,
    parameter int RSP_DEPTH = 4,
    parameter int BANK_W    = 2,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [BANK_W-1:0] rsp_bank,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [BANK_W-1:0] mem_bank,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       rd_cnt
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int RPTR_W = $clog2(RSP_DEPTH);
    localparam int RCNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PEND_W = RCNT_W + 1;
    localparam int REQ_W  = 1 + BANK_W + ADDR_W + DATA_W;
    localparam int RSP_W  = BANK_W + ADDR_W + DATA_W;

    // request FIFO
    logic [REQ_W-1:0]  req_mem [DEPTH];
    logic [PTR_W-1:0]  req_wr_ptr;
    logic [PTR_W-1:0]  req_rd_ptr;
    logic [CNT_W-1:0]  req_count;
    logic              req_push;
    logic              req_pop;
    logic              head_write;
    logic [BANK_W-1:0] head_bank;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    // issue and capture stages
    logic              iss_valid;
    logic              iss_read;
    logic              cap_valid;
    logic [BANK_W-1:0] cap_bank;
    logic [ADDR_W-1:0] cap_addr;
    logic [PEND_W-1:0] reads_pending;

    // response FIFO
    logic [RSP_W-1:0]  rsp_mem [RSP_DEPTH];
    logic [RPTR_W-1:0] rsp_wr_ptr;
    logic [RPTR_W-1:0] rsp_rd_ptr;
    logic [RCNT_W-1:0] rsp_count;
    logic              rsp_push;
    logic              rsp_pop;

    function automatic logic [RPTR_W-1:0] rsp_next(input logic [RPTR_W-1:0] p);
        return (p == RPTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------------------------------------------------------- request FIFO
    assign {head_write, head_bank, head_addr, head_wdata} = req_mem[req_rd_ptr];

    // A pop in the same cycle does not free a slot for the incoming request.
    assign req_ready = (req_count < CNT_W'(DEPTH));
    assign req_push  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (req_push) begin
            req_mem[req_wr_ptr] <= {req_write, req_bank, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
            req_count  <= '0;
        end else begin
            if (req_push) begin
                req_wr_ptr <= req_wr_ptr + 1'b1;
            end
            if (req_pop) begin
                req_rd_ptr <= req_rd_ptr + 1'b1;
            end
            case ({req_push, req_pop})
                2'b10:   req_count <= req_count + 1'b1;
                2'b01:   req_count <= req_count - 1'b1;
                default: req_count <= req_count;
            endcase
        end
    end

    // ---------------------------------------------------------------- issue
    // Every read in flight already owns a response slot, so a capture never finds the
    // response FIFO full even when the client stops taking responses.
    assign iss_read      = iss_valid && !mem_we;
    assign reads_pending = PEND_W'(rsp_count) + PEND_W'(iss_read) + PEND_W'(cap_valid);
    assign req_pop       = (req_count != '0) &&
                           (head_write || (reads_pending < PEND_W'(RSP_DEPTH)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_bank  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
        end else begin
            iss_valid <= req_pop;
            mem_we    <= req_pop && head_write;
            if (req_pop) begin
                mem_bank <= head_bank;
                mem_addr <= head_addr;
                if (head_write) begin
                    mem_wdata <= head_wdata;
                    wr_cnt    <= wr_cnt + 32'd1;
                end else begin
                    rd_cnt <= rd_cnt + 32'd1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- capture
    // mem registers its read one edge after issue; the tag rides alongside until the
    // data is sampled on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_bank  <= '0;
            cap_addr  <= '0;
        end else begin
            cap_valid <= iss_read;
            if (iss_read) begin
                cap_bank <= mem_bank;
                cap_addr <= mem_addr;
            end
        end
    end

    // ---------------------------------------------------------------- response FIFO
    assign rsp_push  = cap_valid;
    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign {rsp_bank, rsp_addr, rsp_data} = rsp_mem[rsp_rd_ptr];

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            rsp_mem[rsp_wr_ptr] <= {cap_bank, cap_addr, mem_rdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            if (rsp_push) begin
                rsp_wr_ptr <= rsp_next(rsp_wr_ptr);
            end
            if (rsp_pop) begin
                rsp_rd_ptr <= rsp_next(rsp_rd_ptr);
            end
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_count <= rsp_count + 1'b1;
                2'b01:   rsp_count <= rsp_count - 1'b1;
                default: rsp_count <= rsp_count;
            endcase
        end
    end

    assign busy = (req_count != '0) || iss_valid || cap_valid;

endmodule
